img_writer: RTL and testbench
=============================

# img_writer

Loads one source frame from a byte-wide pixel stream into the four-bank pixel RAM (bank A-side write ports `wea1..4/ena1..4/AA1..4/DA1..4`) and publishes the count of completed rows on `row_signal`. It is the write-side counterpart of the bilinear scaler, which reads the same RAM through the B-side ports. Pixels are interleaved by row and column parity, so the scaler can fetch any 2x2 neighbourhood in one cycle.

## Interface
- `RAM_AW`, 17, per-bank address width.
- `clk`  in  1  clock; every register is on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `start`  in  1  one-cycle pulse; latches frame size and begins a frame.
- `img0x`  in  32  frame width in pixels; only bits [15:0] are used.
- `img0y`  in  32  frame height in rows; only bits [15:0] are used.
- `s_tdata`  in  8  pixel value.
- `s_tvalid`  in  1  pixel valid.
- `s_tready`  out  1  pixel accepted when `s_tvalid & s_tready`.
- `s_tlast`  in  1  marks the last pixel of a row; used for checking only.
- `wea1..wea4`, `ena1..ena4`  out  1 each  bank write strobe and bank enable.
- `AA1..AA4`  out  RAM_AW each  bank write address.
- `DA1..DA4`  out  8 each  bank write data.
- `row_signal`  out  32  number of rows fully written to the RAM.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `err_tlast`  out  1  sticky `s_tlast` mismatch flag; cleared by `start`.

## Operation
- **States.**
  - IDLE: `s_tready` = 0.
  - RUN: `s_tready` = 1.
  - DONE: `s_tready` = 0, `done` = 1.
- **Transitions.**
  - IDLE or DONE, `start` = 1, width ≠ 0 and height ≠ 0: go to RUN. Latch the width/height; clear `col`, `row`, `base`, `row_signal` and `err_tlast`.
  - IDLE or DONE, `start` = 1, width = 0 or height = 0: go to DONE. Clear `row_signal` and `err_tlast`. No writes.
  - RUN: `start` is ignored.
  - RUN, last pixel (`col` = W-1, `row` = H-1) accepted: go to DONE.
- **Counters.**
  - Internal counters: `col`, `row` (16 bits) and `base` (RAM_AW bits).
  - `half_w` = (W+1)>>1.
- **Bank mapping.**
  - Bank index from {`row[0]`, `col[0]``}`: 00 → bank1, 01 → bank2, 10 → bank3, 11 → bank4.
  - Address = `base` + (`col`>>1), truncated to RAM_AW bits.
  - `base` advances by `half_w` at each row end where `row[0]` = 1. No multiplier.
- **Per accepted pixel.**
  - Registered write stage: on the next cycle exactly one bank has `wea` = `ena` = 1.
  - All four `AA` ports carry the same address; all four `DA` ports carry the same data.
  - Then `col` increments. At W-1, `col` wraps to 0 and `row` increments.
- **`s_tlast` check.**
  - Set `err_tlast` if `s_tlast` = 1 while `col` ≠ W-1, or `s_tlast` = 0 while `col` = W-1.
  - Row framing always follows the counters, never `s_tlast`.
- **`row_signal`.** Increments by 1 on the cycle after the write strobe of a row's last pixel, so the row is already in the RAM when the count rises. Holds its final value (H) in DONE until the next `start`.

## Timing
- Reset values: state IDLE; all `wea`/`ena` 0; `AA`/`DA` 0; `row_signal` 0; `s_tready`, `busy`, `done`, `err_tlast` 0.
- `start` at cycle t: `s_tready` = 1 at t+1.
- Handshake at cycle t: write strobe at t+1, one cycle wide.
- Last pixel of a row handshaken at t: `row_signal` updates at t+2.
- Last pixel of the frame at t: `busy` = 0 and `done` = 1 at t+1. The final write strobe is also at t+1.
- Throughput: one pixel per cycle with no bubbles. `s_tvalid` gaps produce no strobes and no counter changes.
- Reset asserted mid-frame: all state returns immediately to reset values. A pending write is dropped, with no strobe after reset.

## Test plan
- **4x4 frame, continuous stream of values 0..15.**
  - 16 strobes.
  - Pixel (1,2) = 6 → bank3 address 1.
  - Pixel (3,3) = 15 → bank4 address 3.
  - `row_signal` steps 1..4, each update 2 cycles after the row's last handshake.
  - `done` = 1 on the cycle after the last handshake.
- **5x3 frame (odd width), `half_w` = 3.**
  - Pixel (2,4) → bank1 address 5.
  - Pixel (1,3) → bank4 address 1.
  - 15 strobes total; final `row_signal` = 3.
- **4x2 frame with random `s_tvalid` gaps.**
  - Strobe count = 8.
  - Addresses and banks identical to the gap-free run; no strobe during any gap.
- **4x2 frame with `s_tlast` asserted on column 2 of row 0.**
  - `err_tlast` = 1 and stays set.
  - Row boundary still falls after column 3.
  - `start` clears the flag.
- **Size 0x4.** `start` → `done` = 1 at the next cycle, no strobes, `row_signal` = 0.
- **Restart and reset.**
  - `start` issued from DONE after a 4x4 frame: `row_signal` clears to 0 and the second frame writes identically.
  - Reset asserted after 6 pixels: all outputs 0 immediately, no further strobes.

Source files
------------

// File: rtl/img_writer_if.sv
// Byte-wide pixel stream carrying one source frame into img_writer.
// The master drives pixels; the slave (img_writer) returns s_tready.
interface img_writer_if;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/img_writer.sv
// Writes one frame into the four-bank pixel RAM, interleaved by row/column
// parity, and counts rows that have fully landed in the RAM.
module img_writer #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       img0x,
  input  logic [31:0]       img0y,
  img_writer_if.slave       pix,
  output logic              wea1,
  output logic              wea2,
  output logic              wea3,
  output logic              wea4,
  output logic              ena1,
  output logic              ena2,
  output logic              ena3,
  output logic              ena4,
  output logic [RAM_AW-1:0] AA1,
  output logic [RAM_AW-1:0] AA2,
  output logic [RAM_AW-1:0] AA3,
  output logic [RAM_AW-1:0] AA4,
  output logic [7:0]        DA1,
  output logic [7:0]        DA2,
  output logic [7:0]        DA3,
  output logic [7:0]        DA4,
  output logic [31:0]       row_signal,
  output logic              busy,
  output logic              done,
  output logic              err_tlast
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [15:0]       w_q, h_q;
  logic [15:0]       col, row;
  logic [RAM_AW-1:0] base, half_w_q;

  // Write stage: one-hot bank strobe plus shared address/data.
  logic [3:0]        wr_stb;
  logic [RAM_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              row_inc;

  logic              accept, last_col, last_row, size_ok, launch;
  logic [16:0]       w_plus1;
  logic [RAM_AW-1:0] half_w_nx, pix_addr;
  logic              unused_hi;

  assign unused_hi = ^{img0x[31:16], img0y[31:16]};

  assign size_ok   = (img0x[15:0] != 16'd0) && (img0y[15:0] != 16'd0);
  assign launch    = start && (state != S_RUN);
  assign accept    = (state == S_RUN) && pix.s_tvalid;
  assign last_col  = (col == w_q - 16'd1);
  assign last_row  = (row == h_q - 16'd1);
  assign w_plus1   = {1'b0, img0x[15:0]} + 17'd1;
  assign half_w_nx = RAM_AW'(w_plus1[16:1]);
  // Two image rows share one bank row, so base only moves after odd rows.
  assign pix_addr  = base + RAM_AW'(col[15:1]);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_nx     = state;
    pix.s_tready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) state_nx = size_ok ? S_RUN : S_DONE;
      end
      S_RUN: begin
        pix.s_tready = 1'b1;
        busy         = 1'b1;
        if (accept && last_col && last_row) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      half_w_q   <= '0;
      col        <= '0;
      row        <= '0;
      base       <= '0;
      wr_stb     <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      row_inc    <= 1'b0;
      row_signal <= '0;
      err_tlast  <= 1'b0;
    end else begin
      state <= state_nx;
      // NOTE: sequential state uses non-blocking assignments; the strobe
      // defaults low each cycle so it is exactly one cycle wide.
      wr_stb  <= '0;
      row_inc <= 1'b0;

      if (accept) begin
        wr_stb  <= 4'b0001 << {row[0], col[0]};
        wr_addr <= pix_addr;
        wr_data <= pix.s_tdata;
        row_inc <= last_col;
        if (pix.s_tlast != last_col) err_tlast <= 1'b1;
        // Framing follows the counters only; s_tlast is just checked.
        if (last_col) begin
          col <= '0;
          row <= row + 16'd1;
          if (row[0]) base <= base + half_w_q;
        end else begin
          col <= col + 16'd1;
        end
      end

      if (row_inc) row_signal <= row_signal + 32'd1;

      // A new frame wins over a row count still in flight from the old one.
      if (launch) begin
        row_signal <= '0;
        err_tlast  <= 1'b0;
        if (size_ok) begin
          w_q      <= img0x[15:0];
          h_q      <= img0y[15:0];
          half_w_q <= half_w_nx;
          col      <= '0;
          row      <= '0;
          base     <= '0;
        end
      end
    end
  end

  assign wea1 = wr_stb[0];
  assign wea2 = wr_stb[1];
  assign wea3 = wr_stb[2];
  assign wea4 = wr_stb[3];
  assign ena1 = wr_stb[0];
  assign ena2 = wr_stb[1];
  assign ena3 = wr_stb[2];
  assign ena4 = wr_stb[3];
  assign AA1  = wr_addr;
  assign AA2  = wr_addr;
  assign AA3  = wr_addr;
  assign AA4  = wr_addr;
  assign DA1  = wr_data;
  assign DA2  = wr_data;
  assign DA3  = wr_data;
  assign DA4  = wr_data;

  a_stb_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(wr_stb));
  a_cnt_range  : assert property (@(posedge clk) disable iff (!rst)
                                  (state == S_RUN) |-> (col < w_q && row < h_q));

endmodule

// File: tb/tb_img_writer.sv
// Directed bench for img_writer: table of hand-computed pixel placements plus
// multi-cycle sequences for gaps, s_tlast errors, zero size, restart and reset.
module tb_img_writer;

  localparam int RAM_AW = 17;

  typedef struct {
    int w;
    int r;
    int c;
    int bank;
    int addr;
    int data;
  } pix_vec_t;

  typedef struct {
    int cyc;
    int bank;
    int addr;
    int data;
  } stb_rec_t;

  typedef struct {
    int cyc;
    int val;
  } rs_rec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       img0x = '0;
  logic [31:0]       img0y = '0;
  logic              wea1, wea2, wea3, wea4, ena1, ena2, ena3, ena4;
  logic [RAM_AW-1:0] AA1, AA2, AA3, AA4;
  logic [7:0]        DA1, DA2, DA3, DA4;
  logic [31:0]       row_signal;
  logic              busy, done, err_tlast;

  img_writer_if sif ();

  img_writer #(.RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .img0x(img0x), .img0y(img0y),
    .pix(sif),
    .wea1(wea1), .wea2(wea2), .wea3(wea3), .wea4(wea4),
    .ena1(ena1), .ena2(ena2), .ena3(ena3), .ena4(ena4),
    .AA1(AA1), .AA2(AA2), .AA3(AA3), .AA4(AA4),
    .DA1(DA1), .DA2(DA2), .DA3(DA3), .DA4(DA4),
    .row_signal(row_signal), .busy(busy), .done(done), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int glitch   = 0;
  int done_cyc = -1;
  logic        done_prev = 1'b0;
  logic [31:0] rs_prev   = '0;
  stb_rec_t st_q[$];
  rs_rec_t  rs_q[$];
  int       hs_q[$];
  pix_vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe / row-count / done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [3:0] stb;
    int bank;
    stb = {wea4, wea3, wea2, wea1};
    if ({ena4, ena3, ena2, ena1} !== stb) glitch++;
    if (stb !== 4'b0000 && !$onehot(stb)) glitch++;
    if (AA1 !== AA2 || AA1 !== AA3 || AA1 !== AA4) glitch++;
    if (DA1 !== DA2 || DA1 !== DA3 || DA1 !== DA4) glitch++;
    if (stb !== 4'b0000) begin
      bank = (stb == 4'b0001) ? 1 : (stb == 4'b0010) ? 2 : (stb == 4'b0100) ? 3 : 4;
      st_q.push_back('{cyc, bank, int'(AA1), int'(DA1)});
    end
    if (row_signal !== rs_prev) begin
      rs_q.push_back('{cyc, int'(row_signal)});
      rs_prev = row_signal;
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(input int w, input int h);
    @(negedge clk);
    img0x = 32'(w);
    img0y = 32'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    st_q.delete();
    rs_q.delete();
    hs_q.delete();
    done_cyc = -1;
  endtask

  // Streams pixel values 0,1,2,... until `limit` handshakes have happened.
  task automatic send(input int w, input bit gaps, input int bad_col, input int limit);
    int i = 0;
    int steps = 0;
    int r, c;
    bit vld;
    while (i < limit && steps < 2000) begin
      r = i / w;
      c = i % w;
      vld = gaps ? (steps == 1 || $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1 : 1'b1;
      sif.s_tvalid = vld;
      sif.s_tdata  = 8'(i);
      sif.s_tlast  = (c == w - 1) || (r == 0 && c == bad_col);
      if (vld && sif.s_tready) begin
        hs_q.push_back(cyc);
        i++;
      end
      @(negedge clk);
      steps++;
    end
    if (i < limit) check("send_timeout", 64'(i), 64'(limit));
    sif.s_tvalid = 1'b0;
    sif.s_tlast  = 1'b0;
  endtask

  // Independent placement model: bank from parity, address by multiplication.
  task automatic verify_frame(input string name, input int w, input int h);
    int mism;
    int r, c, hw, last;
    check({name, "_strobes"}, 64'(st_q.size()), 64'(w * h));
    check({name, "_rows"}, 64'(rs_q.size()), 64'(h));
    if (st_q.size() != w * h || hs_q.size() != w * h || rs_q.size() != h) return;
    mism = 0;
    hw = (w + 1) / 2;
    for (int i = 0; i < w * h; i++) begin
      r = i / w;
      c = i % w;
      if (st_q[i].bank != 1 + 2 * (r % 2) + (c % 2)) mism++;
      if (st_q[i].addr != (r / 2) * hw + c / 2) mism++;
      if (st_q[i].data != (i & 255)) mism++;
      if (st_q[i].cyc != hs_q[i] + 1) mism++;
    end
    check({name, "_map_errors"}, 64'(mism), 64'd0);
    mism = 0;
    for (int k = 0; k < h; k++) begin
      if (rs_q[k].cyc != hs_q[k * w + w - 1] + 2) mism++;
      if (rs_q[k].val != k + 1) mism++;
    end
    check({name, "_row_timing_errors"}, 64'(mism), 64'd0);
    last = hs_q[w * h - 1];
    check({name, "_done_cycle"}, 64'(done_cyc), 64'(last + 1));
  endtask

  task automatic check_table(input int w);
    int idx;
    foreach (vecs[k]) begin
      if (vecs[k].w == w) begin
        idx = vecs[k].r * w + vecs[k].c;
        if (idx < st_q.size()) begin
          check($sformatf("w%0d_px%0d_%0d_bank", w, vecs[k].r, vecs[k].c), 64'(st_q[idx].bank), 64'(vecs[k].bank));
          check($sformatf("w%0d_px%0d_%0d_addr", w, vecs[k].r, vecs[k].c), 64'(st_q[idx].addr), 64'(vecs[k].addr));
          check($sformatf("w%0d_px%0d_%0d_data", w, vecs[k].r, vecs[k].c), 64'(st_q[idx].data), 64'(vecs[k].data));
        end else begin
          check($sformatf("w%0d_px%0d_%0d_missing", w, vecs[k].r, vecs[k].c), 64'(st_q.size()), 64'(idx + 1));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    // {w, row, col, bank, addr, data}
    vecs[0] = '{4, 1, 2, 3, 1, 6};
    vecs[1] = '{4, 3, 3, 4, 3, 15};
    vecs[2] = '{4, 0, 0, 1, 0, 0};
    vecs[3] = '{4, 0, 1, 2, 0, 1};
    vecs[4] = '{4, 2, 3, 2, 3, 11};
    vecs[5] = '{5, 2, 4, 1, 5, 14};
    vecs[6] = '{5, 1, 3, 4, 1, 8};
    vecs[7] = '{5, 0, 4, 1, 2, 4};
    vecs[8] = '{5, 1, 4, 3, 2, 9};

    sif.s_tdata  = '0;
    sif.s_tvalid = 1'b0;
    sif.s_tlast  = 1'b0;

    idle(2);
    check("reset_outputs", 64'({wea1, wea2, wea3, wea4, ena1, ena2, ena3, ena4, busy, done,
                                err_tlast, sif.s_tready}), 64'd0);
    check("reset_bus", 64'({AA1, DA1, row_signal}), 64'd0);
    rst = 1'b1;
    idle(2);

    // 4x4 continuous frame.
    start_frame(4, 4);
    check("f4x4_ready", 64'(sif.s_tready), 64'd1);
    send(4, 1'b0, -1, 16);
    idle(3);
    verify_frame("f4x4", 4, 4);
    check_table(4);
    check("f4x4_row_signal", 64'(row_signal), 64'd4);
    check("f4x4_done_state", 64'({busy, done, err_tlast}), 64'b010);

    // Restart from DONE: row count clears, frame writes identically.
    start_frame(4, 4);
    check("restart_row_clear", 64'(row_signal), 64'd0);
    check("restart_ready", 64'(sif.s_tready), 64'd1);
    send(4, 1'b0, -1, 16);
    idle(3);
    verify_frame("restart", 4, 4);
    check_table(4);

    // 5x3 odd width.
    start_frame(5, 3);
    send(5, 1'b0, -1, 15);
    idle(3);
    verify_frame("f5x3", 5, 3);
    check_table(5);
    check("f5x3_row_signal", 64'(row_signal), 64'd3);

    // 4x2 with valid gaps.
    start_frame(4, 2);
    send(4, 1'b1, -1, 8);
    idle(3);
    verify_frame("gaps", 4, 2);
    check("gaps_row_signal", 64'(row_signal), 64'd2);
    check("gaps_no_err", 64'(err_tlast), 64'd0);

    // 4x2 with a stray s_tlast on row 0 column 2.
    start_frame(4, 2);
    send(4, 1'b0, 2, 8);
    idle(3);
    check("tlast_err_set", 64'(err_tlast), 64'd1);
    verify_frame("tlast", 4, 2);
    idle(3);
    check("tlast_err_sticky", 64'(err_tlast), 64'd1);
    start_frame(4, 2);
    check("tlast_err_cleared", 64'(err_tlast), 64'd0);
    send(4, 1'b0, -1, 8);
    idle(3);
    check("tlast_clean_frame", 64'(err_tlast), 64'd0);

    // Zero-width frame goes straight to DONE.
    start_frame(0, 4);
    check("zero_done", 64'({busy, done, sif.s_tready}), 64'b010);
    sif.s_tvalid = 1'b1;
    idle(4);
    sif.s_tvalid = 1'b0;
    check("zero_strobes", 64'(st_q.size()), 64'd0);
    check("zero_row_signal", 64'(row_signal), 64'd0);

    // Reset mid-frame after 6 pixels.
    start_frame(4, 4);
    send(4, 1'b0, -1, 6);
    #2;
    n_before = st_q.size();
    check("midreset_strobes_before", 64'(n_before), 64'd6);
    sif.s_tvalid = 1'b1;
    rst = 1'b0;
    #1;
    check("midreset_outputs", 64'({wea1, wea2, wea3, wea4, ena1, ena2, ena3, ena4, busy, done,
                                   err_tlast, sif.s_tready}), 64'd0);
    check("midreset_bus", 64'({AA1, DA1, row_signal}), 64'd0);
    st_q.delete();
    idle(2);
    rst = 1'b1;
    idle(5);
    sif.s_tvalid = 1'b0;
    check("midreset_no_strobes", 64'(st_q.size()), 64'd0);
    check("midreset_idle", 64'({busy, done, sif.s_tready}), 64'd0);

    check("bus_consistency", 64'(glitch), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
